// File: rtl/gfx_pattern_gen.sv
// Raster test-pattern source: one (x, y, color) beat per pixel over pvalid/pready.
// Bars, checker, gradient and solid patterns; one-shot or continuous frames.
module gfx_pattern_gen #(
    parameter int FB_WIDTH    = 640,
    parameter int FB_HEIGHT   = 480,
    parameter int PIXEL_BITS  = 12,
    parameter int NUM_BARS    = 8,
    parameter int CHECK_SHIFT = 5,
    parameter int GRAD_SHIFT  = 5,
    localparam int FB_X_BITS  = $clog2(FB_WIDTH),
    localparam int FB_Y_BITS  = $clog2(FB_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  continuous,
    input  logic [PIXEL_BITS-1:0] solid_color,
    input  logic                  pready,
    output logic                  pvalid,
    output logic [FB_X_BITS-1:0]  x,
    output logic [FB_Y_BITS-1:0]  y,
    output logic [PIXEL_BITS-1:0] color,
    output logic                  last,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int COLOR_BITS = PIXEL_BITS / 3;
    localparam int BAR_W      = FB_WIDTH / NUM_BARS;
    localparam int IB         = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                r_state;
    logic                  r_pvalid;
    logic [FB_X_BITS-1:0]  r_x;
    logic [FB_Y_BITS-1:0]  r_y;
    logic [PIXEL_BITS-1:0] r_color;
    logic                  r_last;
    logic                  r_busy;
    logic                  r_frame_done;
    logic [1:0]            r_mode;
    logic                  r_cont;
    logic [PIXEL_BITS-1:0] r_solid;
    logic [IB-1:0]         r_bar_idx;
    logic [FB_X_BITS-1:0]  r_bar_cnt;

    logic                  w_start;
    logic                  w_adv;
    logic                  w_wrap;
    logic                  w_load;
    logic                  w_x_end;
    logic                  w_y_end;
    logic [1:0]            w_mode;
    logic [PIXEL_BITS-1:0] w_solid;
    logic [FB_X_BITS-1:0]  w_nx;
    logic [FB_Y_BITS-1:0]  w_ny;
    logic [IB-1:0]         w_nidx;
    logic [FB_X_BITS-1:0]  w_ncnt;
    logic                  w_last_n;
    logic [2:0]            w_c3;
    logic                  w_chk;
    logic [COLOR_BITS-1:0] w_grad;
    logic [3*COLOR_BITS-1:0] w_rgb;
    logic [PIXEL_BITS-1:0] w_color;

    assign w_start = (r_state == S_IDLE) && start;
    assign w_adv   = (r_state == S_RUN) && r_pvalid && pready;
    assign w_wrap  = w_adv && r_last;
    // Pattern settings are taken live from the inputs on the cycle they are latched,
    // so the first beat of a frame already uses the new settings.
    assign w_load  = w_start || (w_wrap && r_cont);
    assign w_mode  = w_load ? mode : r_mode;
    assign w_solid = w_load ? solid_color : r_solid;
    assign w_x_end = (r_x == FB_X_BITS'(FB_WIDTH - 1));
    assign w_y_end = (r_y == FB_Y_BITS'(FB_HEIGHT - 1));

    always_comb begin
        w_nx   = '0;
        w_ny   = '0;
        w_nidx = '0;
        w_ncnt = '0;
        if (!w_start && !w_x_end) begin
            w_nx = r_x + 1'b1;
            w_ny = r_y;
            if ((r_bar_cnt == FB_X_BITS'(BAR_W - 1)) && (r_bar_idx != IB'(NUM_BARS - 1))) begin
                w_nidx = r_bar_idx + 1'b1;
            end else begin
                w_nidx = r_bar_idx;
                w_ncnt = r_bar_cnt + 1'b1;
            end
        end else if (!w_start && !w_y_end) begin
            w_ny = r_y + 1'b1;
        end
    end

    assign w_last_n = (w_nx == FB_X_BITS'(FB_WIDTH - 1)) && (w_ny == FB_Y_BITS'(FB_HEIGHT - 1));

    // Colour is derived from the next coordinate so it lands in the same register as x/y.
    always_comb begin
        w_c3    = 3'(w_nidx);
        w_chk   = 1'(w_nx >> CHECK_SHIFT) ^ 1'(w_ny >> CHECK_SHIFT);
        w_grad  = COLOR_BITS'(w_nx >> GRAD_SHIFT);
        w_rgb   = '0;
        w_color = '0;
        case (w_mode)
            2'd0: begin
                w_rgb   = {{COLOR_BITS{~w_c3[1]}}, {COLOR_BITS{~w_c3[2]}}, {COLOR_BITS{~w_c3[0]}}};
                w_color = PIXEL_BITS'(w_rgb);
            end
            2'd1: begin
                w_rgb   = w_chk ? '0 : '1;
                w_color = PIXEL_BITS'(w_rgb);
            end
            2'd2: begin
                w_rgb   = {w_grad, w_grad, w_grad};
                w_color = PIXEL_BITS'(w_rgb);
            end
            default: w_color = w_solid;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pvalid     <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_color      <= '0;
            r_last       <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_mode       <= '0;
            r_cont       <= 1'b0;
            r_solid      <= '0;
            r_bar_idx    <= '0;
            r_bar_cnt    <= '0;
        end else begin
            r_frame_done <= w_wrap;
            if (w_load) begin
                r_mode  <= mode;
                r_cont  <= continuous;
                r_solid <= solid_color;
            end
            if (w_start || w_adv) begin
                r_x       <= w_nx;
                r_y       <= w_ny;
                r_bar_idx <= w_nidx;
                r_bar_cnt <= w_ncnt;
                r_color   <= w_color;
                r_last    <= w_last_n;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_pvalid <= 1'b1;
                    end
                end
                default: begin
                    if (w_wrap && !r_cont) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_pvalid <= 1'b0;
                        r_last   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign pvalid     = r_pvalid;
    assign x          = r_x;
    assign y          = r_y;
    assign color      = r_color;
    assign last       = r_last;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_gfx_pattern_gen.sv
// Directed bench for gfx_pattern_gen on an 8x4 framebuffer with three bars.
module tb_gfx_pattern_gen;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic        continuous;
    logic [11:0] solid_color;
    logic        pready;
    logic        pvalid;
    logic [2:0]  x;
    logic [1:0]  y;
    logic [11:0] color;
    logic        last;
    logic        busy;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    gfx_pattern_gen #(
        .FB_WIDTH   (8),
        .FB_HEIGHT  (4),
        .PIXEL_BITS (12),
        .NUM_BARS   (3),
        .CHECK_SHIFT(1),
        .GRAD_SHIFT (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .continuous (continuous),
        .solid_color(solid_color),
        .pready     (pready),
        .pvalid     (pvalid),
        .x          (x),
        .y          (y),
        .color      (color),
        .last       (last),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {busy, frame_done, pvalid, x, y, color, last}
    function automatic logic [20:0] mk(logic b, logic fd, logic v, int xx, int yy, logic [11:0] c, logic l);
        return {b, fd, v, 3'(xx), 2'(yy), c, l};
    endfunction

    function automatic logic [20:0] obs();
        return {busy, frame_done, pvalid, x, y, color, last};
    endfunction

    function automatic logic [11:0] bars(int xx);
        if (xx < 2) return 12'hFFF;
        if (xx < 4) return 12'hFF0;
        return 12'h0FF;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [20:0] e;
        reset = 1'b1; start = 1'b0; mode = 2'd0; continuous = 1'b0;
        solid_color = 12'h000; pready = 1'b0;
        tick();
        tick();
        e = '0;
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL reset_state: got %h want %h", obs(), e);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_bars();
        logic [20:0] e;
        mode = 2'd0; continuous = 1'b0; pready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            e = mk(1'b1, 1'b0, 1'b1, k % 8, k / 8, bars(k % 8), k == 31);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL bars_beat %0d: got %h want %h", k, obs(), e);
            end
            tick();
        end
        n_cmp++;
        if ({busy, frame_done, pvalid} !== 3'b010) begin
            n_bad++;
            $display("FAIL bars_done: got %b want 010", {busy, frame_done, pvalid});
        end
        tick();
        n_cmp++;
        if ({busy, frame_done, pvalid} !== 3'b000) begin
            n_bad++;
            $display("FAIL bars_idle: got %b want 000", {busy, frame_done, pvalid});
        end
    endtask

    task automatic test_checker();
        logic [20:0] e;
        logic [11:0] c;
        int k = 0;
        mode = 2'd1; continuous = 1'b0; pready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 200 && k < 32; cyc++) begin
            c = (((k % 8) >> 1) & 1) == (((k / 8) >> 1) & 1) ? 12'hFFF : 12'h000;
            e = mk(1'b1, 1'b0, 1'b1, k % 8, k / 8, c, k == 31);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL checker_beat %0d cyc %0d: got %h want %h", k, cyc, obs(), e);
            end
            pready = (cyc % 2 == 0);
            tick();
            if (pready) k++;
        end
        n_cmp++;
        if (k !== 32) begin
            n_bad++;
            $display("FAIL checker_accepts: got %0d want 32", k);
        end
        n_cmp++;
        if ({busy, frame_done, pvalid} !== 3'b010) begin
            n_bad++;
            $display("FAIL checker_done: got %b want 010", {busy, frame_done, pvalid});
        end
        pready = 1'b1;
        tick();
    endtask

    task automatic test_gradient();
        logic [20:0] e;
        mode = 2'd2; continuous = 1'b1; pready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 70; k++) begin
            e = mk(1'b1, (k > 0) && (k % 32 == 0), 1'b1, k % 8, (k / 8) % 4,
                   {3{4'(k % 8)}}, k % 32 == 31);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL gradient_beat %0d: got %h want %h", k, obs(), e);
            end
            tick();
        end
        do_reset();
    endtask

    task automatic test_solid();
        logic [20:0] e;
        mode = 2'd3; continuous = 1'b1; pready = 1'b1; solid_color = 12'hA5C; start = 1'b1;
        tick();
        start = 1'b0;
        mode = 2'd0;
        solid_color = 12'h123;
        for (int k = 0; k < 64; k++) begin
            e = mk(1'b1, k == 32, 1'b1, k % 8, (k / 8) % 4,
                   (k < 32) ? 12'hA5C : bars(k % 8), k % 32 == 31);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL solid_beat %0d: got %h want %h", k, obs(), e);
            end
            tick();
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        logic [20:0] e;
        mode = 2'd0; continuous = 1'b0; pready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        e = mk(1'b1, 1'b0, 1'b1, 2, 1, bars(2), 1'b0);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL midreset_beat10: got %h want %h", obs(), e);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        e = '0;
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL midreset_cleared: got %h want %h", obs(), e);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            e = mk(1'b1, 1'b0, 1'b1, k % 8, k / 8, bars(k % 8), k == 31);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL midreset_restart %0d: got %h want %h", k, obs(), e);
            end
            tick();
        end
        n_cmp++;
        if ({busy, frame_done, pvalid} !== 3'b010) begin
            n_bad++;
            $display("FAIL midreset_done: got %b want 010", {busy, frame_done, pvalid});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [20:0] e;
        mode = 2'd0; continuous = 1'b1; pready = 1'b1; start = 1'b1;
        tick();
        for (int k = 0; k < 70; k++) begin
            e = mk(1'b1, (k > 0) && (k % 32 == 0), 1'b1, k % 8, (k / 8) % 4,
                   bars(k % 8), k % 32 == 31);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL restart_ignored %0d: got %h want %h", k, obs(), e);
            end
            start = (k % 2 == 0);
            tick();
        end
        start = 1'b0;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_bars();
        test_checker();
        test_gradient();
        test_solid();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
